// File: rtl/command_buffer_arbiter.sv
// command_buffer_arbiter: shares the PSL command port among the restart, wed, read and write buffers under credit flow control
//
// Ports
//   clock, rstn      clock and asynchronous active-low reset
//   enabled          arbitration allowed; low forces the ARB_RESET state
//   command_room     PSL initial credit count, sampled in ARB_INIT
//   request          per-buffer request: [0]=restart [1]=wed [2]=read [3]=write
//   command_in       head line of each buffer, valid the cycle after its grant
//   credit_valid     credit_return carries a credit delta this cycle
//   credit_return    signed credit delta from the response
//   grant            registered one-hot pop strobe
//   command_out      registered command toward the PSL, qualified by .valid
//   grant_count      per-requester grant counters (ARB_GRANT_COUNTERS_EN only)
//   credits          currently available credits
//   credit_error     sticky credit underflow/overflow flag
//
// Optional feature: define ARB_GRANT_COUNTERS_EN to add the grant_count output.

package command_buffer_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic [12:0] command;
    logic [7:0]  tag;
    logic [11:0] size;
    logic [63:0] address;
  } CommandBufferLine;
endpackage

module command_buffer_arbiter
  import command_buffer_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int CREDIT_BITS = 8,
  parameter int RR_INIT     = 2
) (
  input  logic                            clock,
  input  logic                            rstn,
  input  logic                            enabled,
  input  logic [CREDIT_BITS-1:0]          command_room,
  input  logic [NUM_REQ-1:0]              request,
  input  CommandBufferLine [NUM_REQ-1:0]  command_in,
  input  logic                            credit_valid,
  input  logic signed [8:0]               credit_return,
  output logic [NUM_REQ-1:0]              grant,
  output CommandBufferLine                command_out,
`ifdef ARB_GRANT_COUNTERS_EN
  output logic [NUM_REQ-1:0][31:0]        grant_count,
`endif
  output logic [CREDIT_BITS-1:0]          credits,
  output logic                            credit_error
);

  typedef enum logic [1:0] {ARB_RESET, ARB_INIT, ARB_IDLE, ARB_GRANT} state_t;

  // Credit math is done two bits wider and signed so that underflow and
  // overflow past the captured room are both visible before clamping.
  localparam int SW = CREDIT_BITS + 2;

  state_t                   state_q, state_d;
  logic [CREDIT_BITS-1:0]   credits_q, credits_d;
  logic [CREDIT_BITS-1:0]   room_q, room_d;
  logic                     err_q, err_d;
  logic                     rr_write_q, rr_write_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [NUM_REQ-1:0]       pend_q;
  CommandBufferLine         cmd_q, cmd_d, sel;
  logic signed [SW-1:0]     ret_ext, eff, nxt;
  logic                     active, can_grant, rw_write, under, over;
  logic [1:0]               win;

  always_comb begin
    ret_ext   = credit_valid ? {{(SW-9){credit_return[8]}}, credit_return} : '0;
    eff       = $signed({2'b00, credits_q}) + ret_ext;
    active    = enabled && (state_q == ARB_IDLE || state_q == ARB_GRANT);
    // A credit returned this cycle is already usable for this cycle's grant.
    can_grant = active && !eff[SW-1] && |eff;
    // Read and write alternate; a lone requester wins regardless of the pointer.
    rw_write  = request[3] && (!request[2] || rr_write_q);
    win       = request[0] ? 2'd0 : request[1] ? 2'd1 : rw_write ? 2'd3 : 2'd2;
    grant_d   = (can_grant && |request) ? NUM_REQ'(1) << win : '0;
    rr_write_d = grant_d[2] ? 1'b1 : grant_d[3] ? 1'b0 : rr_write_q;
    nxt       = eff - $signed({{(SW-1){1'b0}}, |grant_d});
    under     = nxt[SW-1];
    over      = !under && (nxt > $signed({2'b00, room_q}));
    room_d    = (enabled && state_q == ARB_INIT) ? command_room : room_q;
    credits_d = !enabled ? '0 :
                state_q == ARB_INIT ? command_room :
                !active ? '0 :
                under ? '0 :
                over ? room_q : nxt[CREDIT_BITS-1:0];
    err_d     = state_q == ARB_RESET ? 1'b0 : err_q | (active & (under | over));
    state_d   = !enabled ? ARB_RESET :
                state_q == ARB_RESET ? ARB_INIT :
                state_q == ARB_INIT ? ARB_IDLE :
                |grant_d ? ARB_GRANT : ARB_IDLE;
  end

  // The line of the buffer granted last cycle is on command_in now; capture it
  // even if arbitration has since been disabled.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) sel = pend_q[i] ? command_in[i] : sel;
    cmd_d = '0;
    if (|pend_q) begin
      cmd_d = sel;
      cmd_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ARB_RESET;
      credits_q  <= '0;
      room_q     <= '0;
      err_q      <= 1'b0;
      rr_write_q <= (RR_INIT == 3);
      grant_q    <= '0;
      pend_q     <= '0;
      cmd_q      <= '0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      room_q     <= room_d;
      err_q      <= err_d;
      rr_write_q <= rr_write_d;
      grant_q    <= grant_d;
      pend_q     <= grant_q;
      cmd_q      <= cmd_d;
    end
  end

`ifdef ARB_GRANT_COUNTERS_EN
  logic [NUM_REQ-1:0][31:0] cnt_q;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        cnt_q[i] <= state_q == ARB_RESET ? 32'd0 : cnt_q[i] + 32'(grant_d[i]);
  end

  assign grant_count = cnt_q;
`endif

  assign grant        = grant_q;
  assign command_out  = cmd_q;
  assign credits      = credits_q;
  assign credit_error = err_q;

endmodule

// File: tb/tb_command_buffer_arbiter.sv
// tb_command_buffer_arbiter: table, directed and randomized checks of command_buffer_arbiter
module tb_command_buffer_arbiter;
  import command_buffer_arbiter_pkg::*;

  localparam int LW = $bits(CommandBufferLine);

  logic                    clock;
  logic                    rstn;
  logic                    enabled;
  logic [7:0]              command_room;
  logic [3:0]              request;
  CommandBufferLine [3:0]  command_in;
  logic                    credit_valid;
  logic signed [8:0]       credit_return;
  logic [3:0]              grant;
  CommandBufferLine        command_out;
  logic [7:0]              credits;
  logic                    credit_error;
`ifdef ARB_GRANT_COUNTERS_EN
  logic [3:0][31:0]        grant_count;
`endif

  command_buffer_arbiter dut (
    .clock        (clock),
    .rstn         (rstn),
    .enabled      (enabled),
    .command_room (command_room),
    .request      (request),
    .command_in   (command_in),
    .credit_valid (credit_valid),
    .credit_return(credit_return),
    .grant        (grant),
    .command_out  (command_out),
`ifdef ARB_GRANT_COUNTERS_EN
    .grant_count  (grant_count),
`endif
    .credits      (credits),
    .credit_error (credit_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0=reset, 1=init, 2=running (idle and granting are
  // one phase here); grants are tracked as buffer indices, -1 for none.
  int m_phase, m_cred, m_room, m_rr, m_vis, m_prev;
  bit m_err;
  CommandBufferLine m_cmd;

  function automatic CommandBufferLine captured(CommandBufferLine l);
    l.valid = 1'b1;
    return l;
  endfunction

  function automatic CommandBufferLine fixed_line(int i);
    CommandBufferLine l;
    l.valid   = 1'b1;
    l.command = 13'(16'h100 + i);
    l.tag     = 8'(i + 1);
    l.size    = 12'd64;
    l.address = 64'(32'h1000 * (i + 1));
    return l;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cred = 0; m_room = 0; m_rr = 2; m_vis = -1; m_prev = -1;
    m_err = 0; m_cmd = '0;
  endtask

  task automatic step();
    int eff, g, n;
    eff = m_cred + (credit_valid ? int'(credit_return) : 0);
    g = -1;
    if (enabled && m_phase == 2 && eff > 0) begin
      if (request[0]) g = 0;
      else if (request[1]) g = 1;
      else if (request[2] && request[3]) g = m_rr;
      else if (request[2]) g = 2;
      else if (request[3]) g = 3;
    end
    m_cmd = m_prev >= 0 ? captured(command_in[m_prev]) : '0;
    m_prev = m_vis;
    m_vis = g;
    if (g == 2) m_rr = 3;
    else if (g == 3) m_rr = 2;
    if (!enabled) begin
      if (m_phase == 0) m_err = 0;
      m_phase = 0; m_cred = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_cred = 0; m_err = 0;
    end else if (m_phase == 1) begin
      m_phase = 2; m_room = int'(command_room); m_cred = m_room;
    end else begin
      n = eff - (g >= 0 ? 1 : 0);
      if (n < 0) begin n = 0; m_err = 1; end
      else if (n > m_room) begin n = m_room; m_err = 1; end
      m_cred = n;
    end
    @(posedge clock); #1;
  endtask

  task automatic check_model();
    check("model_grant", grant, m_vis < 0 ? 4'd0 : 4'(1 << m_vis));
    check("model_cmd", command_out, m_cmd);
    check("model_credits", credits, 8'(m_cred));
    check("model_err", credit_error, m_err);
  endtask

  task automatic do_reset(int room);
    rstn = 1'b0; enabled = 1'b1; command_room = 8'(room); request = '0;
    credit_valid = 1'b0; credit_return = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 rstn = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       cv;
    int         cr;
    logic [3:0] g;
    int         cred;
    int         cidx;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int ngr;
    tbl[0]  = '{4'b1111, 1'b0,  0, 4'b0001, 63, -1};
    tbl[1]  = '{4'b1111, 1'b0,  0, 4'b0001, 62, -1};
    tbl[2]  = '{4'b1110, 1'b0,  0, 4'b0010, 61,  0};
    tbl[3]  = '{4'b1110, 1'b0,  0, 4'b0010, 60,  0};
    tbl[4]  = '{4'b1100, 1'b0,  0, 4'b0100, 59,  1};
    tbl[5]  = '{4'b1100, 1'b0,  0, 4'b1000, 58,  1};
    tbl[6]  = '{4'b1100, 1'b0,  0, 4'b0100, 57,  2};
    tbl[7]  = '{4'b1000, 1'b0,  0, 4'b1000, 56,  3};
    tbl[8]  = '{4'b0100, 1'b0,  0, 4'b0100, 55,  2};
    tbl[9]  = '{4'b0000, 1'b0,  0, 4'b0000, 55,  3};
    tbl[10] = '{4'b0000, 1'b0,  0, 4'b0000, 55,  2};
    tbl[11] = '{4'b0000, 1'b0,  0, 4'b0000, 55, -1};
    tbl[12] = '{4'b0000, 1'b1, -5, 4'b0000, 50, -1};
    tbl[13] = '{4'b0100, 1'b1,  1, 4'b0100, 50, -1};
    tbl[14] = '{4'b0000, 1'b0,  0, 4'b0000, 50, -1};
    tbl[15] = '{4'b0000, 1'b0,  0, 4'b0000, 50,  2};

    for (int i = 0; i < 4; i++) command_in[i] = fixed_line(i);

    // Reset and init
    do_reset(64);
    check("rst_grant", grant, 4'd0);
    check("rst_cmd", command_out, 0);
    check("rst_credits", credits, 8'd0);
    check("rst_err", credit_error, 1'b0);
    step();
    check("init1_credits", credits, 8'd0);
    step();
    check("init2_credits", credits, 8'd64);

    // Priority and pipeline table
    for (int i = 0; i < 16; i++) begin
      request = tbl[i].req; credit_valid = tbl[i].cv; credit_return = 9'(tbl[i].cr);
      step();
      check($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      check($sformatf("tbl%0d_credits", i), credits, 8'(tbl[i].cred));
      check($sformatf("tbl%0d_cmd", i), command_out,
            tbl[i].cidx < 0 ? '0 : captured(fixed_line(tbl[i].cidx)));
      check($sformatf("tbl%0d_err", i), credit_error, 1'b0);
    end
    credit_valid = 1'b0; credit_return = '0;

    // Credit exhaustion
    do_reset(2);
    step(); step();
    request = 4'b1100; ngr = 0;
    repeat (4) begin
      step();
      ngr += (grant != 0) ? 1 : 0;
    end
    check("exh_grants", 32'(ngr), 32'd2);
    check("exh_credits", credits, 8'd0);
    credit_valid = 1'b1; credit_return = 9'sd1;
    step();
    check("exh_ret_grant", grant, 4'b0100);
    check("exh_ret_credits", credits, 8'd0);
    credit_valid = 1'b0;
    step();
    check("exh_after_grant", grant, 4'd0);

    // Simultaneous grant and return, overflow clamp, sticky error
    do_reset(8);
    step(); step();
    request = 4'b0100;
    repeat (3) step();
    check("sim_credits5", credits, 8'd5);
    credit_valid = 1'b1; credit_return = 9'sd1;
    step();
    check("sim_grant", grant, 4'b0100);
    check("sim_credits", credits, 8'd5);
    request = '0; credit_return = 9'sd10;
    step();
    check("ovf_credits", credits, 8'd8);
    check("ovf_err", credit_error, 1'b1);
    credit_valid = 1'b0;
    step();
    check("ovf_sticky", credit_error, 1'b1);
    enabled = 1'b0;
    step(); step();
    check("ovf_cleared", credit_error, 1'b0);

    // Disable mid-stream
    do_reset(64);
    command_in[2] = fixed_line(2);
    step(); step();
    request = 4'b0100;
    step();
    check("dis_first_grant", grant, 4'b0100);
    enabled = 1'b0;
    step();
    check("dis_no_grant", grant, 4'd0);
    check("dis_credits", credits, 8'd0);
    step();
    check("dis_cmd_pulse", command_out, captured(fixed_line(2)));
    check("dis_no_grant2", grant, 4'd0);
    step();
    check("dis_cmd_end", command_out, 0);
    command_room = 8'd20; enabled = 1'b1;
    step();
    check("reen_credits0", credits, 8'd0);
    step();
    check("reen_credits", credits, 8'd20);
    step();
    check("reen_grant", grant, 4'b0100);
    check("reen_credits_after", credits, 8'd19);

`ifdef ARB_GRANT_COUNTERS_EN
    do_reset(64);
    step(); step();
    request = 4'b0100;
    repeat (10) step();
    request = '0;
    step();
    for (int i = 0; i < 4; i++)
      check($sformatf("cnt%0d", i), grant_count[i], i == 2 ? 32'd10 : 32'd0);
`endif

    // Randomized against the reference model
    do_reset(int'($urandom_range(1, 16)));
    check_model();
    for (int c = 0; c < 2000; c++) begin
      logic [LW-1:0] tmp;
      int r;
      enabled = $urandom_range(99) < 97;
      request = 4'($urandom);
      credit_valid = $urandom_range(3) == 0;
      r = ($urandom_range(9) == 0) ? int'($urandom_range(40)) - 20 : int'($urandom_range(4)) - 2;
      credit_return = 9'(r);
      command_room = 8'($urandom_range(1, 24));
      for (int i = 0; i < 4; i++) begin
        tmp = LW'({$urandom, $urandom, $urandom, $urandom});
        command_in[i] = tmp;
      end
      step();
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/command_buffer_arbiter.md
Name: command_buffer_arbiter

Overview:
- Shares the single PSL command interface among four command buffers: restart, wed, read and write.
- Grants one buffer per cycle under PSL command-credit flow control. Captures the popped CommandBufferLine and drives it registered toward the PSL command port.
- Tracks outstanding credits from the initial room value and from credits returned in ResponseBufferLine.response_credits.

Parameters:
- NUM_REQ, 4, number of requesters. Fixed order: [0]=restart, [1]=wed, [2]=read, [3]=write.
- CREDIT_BITS, 8, width of the credit counter; matches the ha_croom width.
- RR_INIT, 2, index of the read/write requester that wins the first read-vs-write tie after reset.

Ports:
- clock  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- enabled  in  1  arbiter may grant only while high.
- command_room  in  CREDIT_BITS  PSL initial credit count (ha_croom); sampled in ARB_INIT.
- request  in  NUM_REQ  per-buffer not-empty/request; bit order as in NUM_REQ.
- command_in  in  NUM_REQ x CommandBufferLine  head line of each buffer; valid one cycle after its grant.
- credit_valid  in  1  a response carrying credits has arrived.
- credit_return  in  9  signed credit delta from response_credits.
- grant  out  NUM_REQ  one-hot pop strobe to the buffers; registered.
- command_out  out  CommandBufferLine  registered command toward the PSL; valid field qualifies it.
- credits  out  CREDIT_BITS  current available credits.
- credit_error  out  1  sticky flag: credit underflow or overflow.

Behaviour:
- Reset:
  - All outputs 0: grant=0, command_out=0 (valid=0), credits=0, credit_error=0.
  - Round-robin pointer = RR_INIT. State = ARB_RESET.
- State machine:
  - ARB_RESET -> ARB_INIT when enabled=1.
  - ARB_INIT, one cycle: credits <= command_room; -> ARB_IDLE.
  - ARB_IDLE -> ARB_GRANT when any request bit is set and credits_eff > 0.
  - ARB_GRANT stays while requests and credits remain. Returns to ARB_IDLE otherwise.
  - enabled=0 in any state -> ARB_RESET on the next edge. Grant is suppressed and credits are cleared. Any in-flight capture still completes, so command_out.valid can still pulse once.
- Eligibility: a grant is issued only when enabled=1, the state is IDLE or GRANT, and credits_eff > 0. credits_eff = credits + (credit_valid ? credit_return : 0), so a credit returned this cycle is usable this cycle.
- Priority:
  - restart is strict highest, then wed.
  - read and write alternate round-robin. After a read or write grant, the pointer moves to the other one.
  - A restart or wed grant does not move the pointer.
- Grant pipeline:
  - Grant is registered, one-hot, and one cycle wide. At most one grant per cycle, so back-to-back grants give one command per cycle.
  - Grant at cycle N -> the buffer presents its line at N+1 -> the arbiter latches it into command_out at N+2 with valid=1.
  - command_out.valid pulses for exactly one cycle per grant.
- Credit arithmetic, every cycle: credits_next = credits - grant_issued + (credit_valid ? credit_return : 0), computed at CREDIT_BITS+2 bits signed.
  - Result < 0: clamp to 0 and set credit_error.
  - Result > captured room: clamp to room and set credit_error.
  - Simultaneous grant and return of +1: credits unchanged.
- credit_error is sticky until rstn or a pass through ARB_RESET.
- Request bits must stay stable until granted. A request withdrawn without a grant is legal and is simply not granted.

Optional Feature:
- Macro: ARB_GRANT_COUNTERS_EN.
- Defined: adds the output grant_count, NUM_REQ x 32, one counter per requester, reset to 0. Each counter increments on that requester's grant, wraps at 2^32 and clears in ARB_RESET.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset/init: rstn low, enabled=1, command_room=64, release rstn -> credits=0 in ARB_RESET, credits=64 two cycles later, all outputs 0 beforehand.
- Priority: request=4'b1111 with 64 credits -> grant order restart, wed, read, write, read, write..., with each restart/wed grant held while its request stays high. command_out.valid appears 2 cycles after each grant.
- Credit exhaustion: command_room=2, read and write requesting, no returns -> exactly 2 grants, credits=0, no further grants. credit_valid with credit_return=+1 -> a grant in that same cycle and credits stays 0.
- Simultaneous events: credits=5, grant plus credit_return=+1 in the same cycle -> credits=5. credit_return=+10 with room=8 at credits=5 -> credits=8 and credit_error=1.
- Disable mid-stream: drop enabled one cycle after a grant -> no new grants, that grant's command_out.valid still pulses, credits=0. Re-enable -> ARB_INIT reloads command_room.
- With ARB_GRANT_COUNTERS_EN: 10 read-only grants -> grant_count[read]=10, all other counters 0.
